xbar_src_router: RTL and testbench

- Source-side requester for one crossbar input port.
- Accepts an AXI-Stream-style packet with a TDEST field and raises a one-hot request toward the destination's output arbiter.
- Forwards beats once the arbiter grants the destination, and pulses a per-destination packet-end strobe into the arbiter's last input.
- One instance per crossbar slave port; the request_o, grant_i and last_o buses wire directly to the output round-robin arbiters.

---
 rtl/xbar_pkg.sv | 34 +++
 rtl/xbar_dest_decode.sv | 27 ++
 rtl/xbar_src_router.sv | 171 +++++++++++++++++
 tb/tb_xbar_src_router.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// -----------------------------------------------------------------------------
// xbar_pkg
// Shared types and helpers for the crossbar source-side router.
//   state_e       : router FSM states (IDLE, REQ, XFER, DROP)
//   DEFAULT_*     : default payload width and destination count
//   MAX_MASTERS   : widest one-hot vector the onehot() helper can build
//   onehot(i, n)  : one-hot vector with bit i set, or all zeros if i >= n
// -----------------------------------------------------------------------------
package xbar_pkg;

  localparam int DEFAULT_T_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_MASTERS  = 4;
  localparam int MAX_MASTERS          = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } state_e;

  // An index outside [0, n) yields an all-zero vector, so callers can derive
  // an in-range flag by OR-reducing the result.
  function automatic logic [MAX_MASTERS-1:0] onehot(input int unsigned idx,
                                                    input int unsigned n);
    logic [MAX_MASTERS-1:0] vec;
    vec = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      vec[i] = (i == idx) && (i < n);
    end
    return vec;
  endfunction

endpackage

// File: rtl/xbar_dest_decode.sv
// -----------------------------------------------------------------------------
// xbar_dest_decode
// Combinational binary-to-one-hot decoder for a crossbar destination index.
//   dest_i      in   DEST_WIDTH   binary destination index
//   onehot_o    out  NUM_MASTERS  one-hot destination (zero when out of range)
//   in_range_o  out  1            dest_i addresses an existing output
// -----------------------------------------------------------------------------
module xbar_dest_decode
  import xbar_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
  parameter int DEST_WIDTH  = 2
) (
  input  logic [DEST_WIDTH-1:0]  dest_i,
  output logic [NUM_MASTERS-1:0] onehot_o,
  output logic                   in_range_o
);

  logic [MAX_MASTERS-1:0] onehot_full;

  always_comb begin
    onehot_full = onehot(32'(dest_i), 32'(NUM_MASTERS));
    onehot_o    = onehot_full[NUM_MASTERS-1:0];
    in_range_o  = |onehot_full;
  end

endmodule

// File: rtl/xbar_src_router.sv
// -----------------------------------------------------------------------------
// xbar_src_router
// Source-side requester for one crossbar input port. Takes an AXI-Stream-style
// packet, requests the destination's output arbiter, forwards beats once
// granted and strobes the arbiter's last input on the final beat. Packets
// addressed to a non-existent output are consumed and discarded.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_last_i/s_dest_i/s_ready_o   input stream
//   request_o         one-hot registered arbitration request
//   grant_i           per-output grants from the arbiters
//   last_o            one-hot packet-end strobe to the arbiters
//   m_data_o/m_last_o payload and last flag shared by all outputs
//   m_valid_o         one-hot valid toward the selected output
//   m_ready_i         per-output ready
//   drop_cnt_o        saturating count of dropped packets
//
// Configuration macro: XBAR_SRC_ROUTER_DROP_CNT_EN enables the drop counter;
// without it drop_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module xbar_src_router
  import xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = DEFAULT_T_DATA_WIDTH,
  parameter int NUM_MASTERS  = DEFAULT_NUM_MASTERS,
  parameter int DEST_WIDTH   = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic                    s_valid_i,
  input  logic                    s_last_i,
  input  logic [DEST_WIDTH-1:0]   s_dest_i,
  output logic                    s_ready_o,
  output logic [NUM_MASTERS-1:0]  request_o,
  input  logic [NUM_MASTERS-1:0]  grant_i,
  output logic [NUM_MASTERS-1:0]  last_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic [NUM_MASTERS-1:0]  m_valid_o,
  input  logic [NUM_MASTERS-1:0]  m_ready_i,
  output logic [CNT_WIDTH-1:0]    drop_cnt_o
);

  state_e                 state_q, state_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;
  logic [NUM_MASTERS-1:0] request_q, request_d;

  logic [DEST_WIDTH-1:0]  dec_dest;
  logic [NUM_MASTERS-1:0] dest_onehot;
  logic                   dest_in_range;
  logic                   grant_sel;
  logic                   ready_sel;

  // In IDLE the incoming header is decoded; afterwards the latched dest_q is,
  // so one decoder serves both the request decision and the output select.
  assign dec_dest = (state_q == IDLE) ? s_dest_i : dest_q;

  xbar_dest_decode #(
    .NUM_MASTERS (NUM_MASTERS),
    .DEST_WIDTH  (DEST_WIDTH)
  ) u_dest_decode (
    .dest_i     (dec_dest),
    .onehot_o   (dest_onehot),
    .in_range_o (dest_in_range)
  );

  // Masking with the one-hot destination ignores grants/readies for outputs
  // this port does not target.
  assign grant_sel = |(grant_i & dest_onehot);
  assign ready_sel = |(m_ready_i & dest_onehot);

  assign request_o = request_q;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    request_d = request_q;
    s_ready_o = 1'b0;
    m_valid_o = '0;
    last_o    = '0;
    m_data_o  = '0;
    m_last_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid_i) begin
          dest_d = s_dest_i;
          if (dest_in_range) begin
            state_d   = REQ;
            request_d = dest_onehot;
          end else begin
            state_d   = DROP;
            request_d = '0;
          end
        end
      end

      REQ: begin
        if (grant_sel) begin
          state_d = XFER;
        end
      end

      XFER: begin
        // A grant withdrawn mid-packet simply stalls both sides; the beat
        // stays on s_data_i until the grant returns.
        s_ready_o = ready_sel & grant_sel;
        m_valid_o = (s_valid_i & grant_sel) ? dest_onehot : '0;
        m_data_o  = s_data_i;
        m_last_o  = s_last_i;
        if (s_valid_i && s_ready_o && s_last_i) begin
          last_o    = dest_onehot;
          request_d = '0;
          state_d   = IDLE;
        end
      end

      DROP: begin
        s_ready_o = 1'b1;
        if (s_valid_i && s_last_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        request_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      request_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      request_q <= request_d;
    end
  end

`ifdef XBAR_SRC_ROUTER_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Counts entries into DROP, sticking at all-ones rather than wrapping.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == IDLE) && s_valid_i && !dest_in_range && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xbar_src_router.sv
// -----------------------------------------------------------------------------
// tb_xbar_src_router
// Directed bench for xbar_src_router. A 4-output instance carries the routed
// traffic; a 3-output instance exercises the out-of-range drop path. Beats
// offered to the 4-output instance are queued as expected output and matched
// against every output handshake.
// -----------------------------------------------------------------------------
module tb_xbar_src_router;

  logic       clk;
  logic       rst_n;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic [1:0] s_dest;
  logic       s_ready;
  logic [3:0] request;
  logic [3:0] grant;
  logic [3:0] last_o;
  logic [7:0] m_data;
  logic       m_last;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] drop_cnt;

  logic [7:0] d3_s_data;
  logic       d3_s_valid;
  logic       d3_s_last;
  logic [1:0] d3_s_dest;
  logic       d3_s_ready;
  logic [2:0] d3_request;
  logic [2:0] d3_last_o;
  logic [7:0] d3_m_data;
  logic       d3_m_last;
  logic [2:0] d3_m_valid;
  logic [7:0] d3_drop_cnt;

`ifdef XBAR_SRC_ROUTER_DROP_CNT_EN
  localparam int EXP_DROP_CNT = 1;
`else
  localparam int EXP_DROP_CNT = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_beat;

  int checks = 0;
  int errors = 0;

  xbar_src_router #(
    .T_DATA_WIDTH (8),
    .NUM_MASTERS  (4),
    .DEST_WIDTH   (2),
    .CNT_WIDTH    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_i   (s_data),
    .s_valid_i  (s_valid),
    .s_last_i   (s_last),
    .s_dest_i   (s_dest),
    .s_ready_o  (s_ready),
    .request_o  (request),
    .grant_i    (grant),
    .last_o     (last_o),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .drop_cnt_o (drop_cnt)
  );

  xbar_src_router #(
    .T_DATA_WIDTH (8),
    .NUM_MASTERS  (3),
    .DEST_WIDTH   (2),
    .CNT_WIDTH    (8)
  ) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_i   (d3_s_data),
    .s_valid_i  (d3_s_valid),
    .s_last_i   (d3_s_last),
    .s_dest_i   (d3_s_dest),
    .s_ready_o  (d3_s_ready),
    .request_o  (d3_request),
    .grant_i    (3'b111),
    .last_o     (d3_last_o),
    .m_data_o   (d3_m_data),
    .m_last_o   (d3_m_last),
    .m_valid_o  (d3_m_valid),
    .m_ready_i  (3'b111),
    .drop_cnt_o (d3_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic last, input logic [1:0] dest);
    s_valid = valid;
    s_data  = data;
    s_last  = last;
    s_dest  = dest;
  endtask

  task automatic pushBeat(input logic [7:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake must match the oldest queued beat.
  always @(negedge clk) begin
    if (rst_n && ((m_valid & m_ready) != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_beat = exp_q.pop_front();
        checkOutput("sb_data", 32'(m_data), 32'(exp_beat.data));
        checkOutput("sb_last", 32'(m_last), 32'(exp_beat.last));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n   = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    grant   = 4'b0000;
    m_ready = 4'b1111;
    d3_s_valid = 1'b0;
    d3_s_data  = 8'h00;
    d3_s_last  = 1'b0;
    d3_s_dest  = 2'd0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_request", 32'(request), 32'h0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'h0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'h0);
    checkOutput("rst_last_o", 32'(last_o), 32'h0);
    checkOutput("rst_m_data", 32'(m_data), 32'h0);
    checkOutput("rst_drop_cnt", 32'(d3_drop_cnt), 32'h0);
    #2 rst_n = 1'b1;

    // Single 3-beat packet to dest 2, grant two cycles after request
    nextCycle(); applyStimulus(1'b1, 8'hA1, 1'b0, 2'd2); pushBeat(8'hA1, 1'b0);
    @(negedge clk);
    checkOutput("t1_idle_ready", 32'(s_ready), 32'h0);
    checkOutput("t1_idle_request", 32'(request), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t1_request", 32'(request), 32'h4);
    checkOutput("t1_req_valid", 32'(m_valid), 32'h0);
    checkOutput("t1_req_ready", 32'(s_ready), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t1_wait_valid", 32'(m_valid), 32'h0);
    nextCycle(); grant = 4'b0100; @(negedge clk);
    checkOutput("t1_grant_cycle_valid", 32'(m_valid), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t1_xfer_valid", 32'(m_valid), 32'h4);
    checkOutput("t1_xfer_ready", 32'(s_ready), 32'h1);
    checkOutput("t1_xfer_last_o", 32'(last_o), 32'h0);
    nextCycle(); applyStimulus(1'b1, 8'hA2, 1'b0, 2'd2); pushBeat(8'hA2, 1'b0);
    @(negedge clk);
    checkOutput("t1_beat2_valid", 32'(m_valid), 32'h4);
    nextCycle(); applyStimulus(1'b1, 8'hA3, 1'b1, 2'd2); pushBeat(8'hA3, 1'b1);
    @(negedge clk);
    checkOutput("t1_last_o", 32'(last_o), 32'h4);
    nextCycle(); applyStimulus(1'b0, 8'h00, 1'b0, 2'd0); grant = 4'b0000;
    @(negedge clk);
    checkOutput("t1_request_after", 32'(request), 32'h0);
    checkOutput("t1_last_o_after", 32'(last_o), 32'h0);

    // Backpressure on dest 1: m_ready[1] goes 1,0,0,1
    nextCycle(); applyStimulus(1'b1, 8'hB1, 1'b0, 2'd1); pushBeat(8'hB1, 1'b0);
    @(negedge clk);
    nextCycle(); grant = 4'b0010; m_ready = 4'b0010; @(negedge clk);
    checkOutput("t2_request", 32'(request), 32'h2);
    checkOutput("t2_req_ready", 32'(s_ready), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t2_ready_hi", 32'(s_ready), 32'h1);
    checkOutput("t2_data_b1", 32'(m_data), 32'hB1);
    nextCycle(); applyStimulus(1'b1, 8'hB2, 1'b0, 2'd1); pushBeat(8'hB2, 1'b0);
    m_ready = 4'b0000; @(negedge clk);
    checkOutput("t2_stall1_ready", 32'(s_ready), 32'h0);
    checkOutput("t2_stall1_valid", 32'(m_valid), 32'h2);
    checkOutput("t2_stall1_data", 32'(m_data), 32'hB2);
    nextCycle(); @(negedge clk);
    checkOutput("t2_stall2_ready", 32'(s_ready), 32'h0);
    checkOutput("t2_stall2_data", 32'(m_data), 32'hB2);
    nextCycle(); m_ready = 4'b0010; @(negedge clk);
    checkOutput("t2_resume_ready", 32'(s_ready), 32'h1);
    nextCycle(); applyStimulus(1'b1, 8'hB3, 1'b1, 2'd1); pushBeat(8'hB3, 1'b1);
    @(negedge clk);
    checkOutput("t2_last_o", 32'(last_o), 32'h2);
    nextCycle(); applyStimulus(1'b0, 8'h00, 1'b0, 2'd0); grant = 4'b0000;
    m_ready = 4'b1111; @(negedge clk);
    checkOutput("t2_request_after", 32'(request), 32'h0);

    // Wrong grant for dest 3, then a grant dropout mid-packet
    nextCycle(); applyStimulus(1'b1, 8'hC1, 1'b0, 2'd3); pushBeat(8'hC1, 1'b0);
    grant = 4'b0001; @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      nextCycle(); @(negedge clk);
      checkOutput("t3_wrong_grant_request", 32'(request), 32'h8);
      checkOutput("t3_wrong_grant_valid", 32'(m_valid), 32'h0);
      checkOutput("t3_wrong_grant_ready", 32'(s_ready), 32'h0);
    end
    nextCycle(); grant = 4'b1000; @(negedge clk);
    checkOutput("t3_grant_cycle_valid", 32'(m_valid), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t3_xfer_valid", 32'(m_valid), 32'h8);
    checkOutput("t3_xfer_data", 32'(m_data), 32'hC1);
    nextCycle(); applyStimulus(1'b1, 8'hC2, 1'b1, 2'd3); pushBeat(8'hC2, 1'b1);
    grant = 4'b0000; @(negedge clk);
    checkOutput("t3_grant_lost_valid", 32'(m_valid), 32'h0);
    checkOutput("t3_grant_lost_ready", 32'(s_ready), 32'h0);
    checkOutput("t3_grant_lost_last_o", 32'(last_o), 32'h0);
    nextCycle(); grant = 4'b1000; @(negedge clk);
    checkOutput("t3_regrant_valid", 32'(m_valid), 32'h8);
    checkOutput("t3_last_o", 32'(last_o), 32'h8);
    nextCycle(); applyStimulus(1'b0, 8'h00, 1'b0, 2'd0); grant = 4'b0000;
    @(negedge clk);
    checkOutput("t3_request_after", 32'(request), 32'h0);

    // Out-of-range destination on the 3-output instance
    nextCycle(); d3_s_valid = 1'b1; d3_s_data = 8'hD1; d3_s_last = 1'b0; d3_s_dest = 2'd3;
    @(negedge clk);
    checkOutput("t4_idle_ready", 32'(d3_s_ready), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t4_drop_ready", 32'(d3_s_ready), 32'h1);
    checkOutput("t4_drop_request", 32'(d3_request), 32'h0);
    checkOutput("t4_drop_valid", 32'(d3_m_valid), 32'h0);
    nextCycle(); d3_s_data = 8'hD2; d3_s_last = 1'b1; @(negedge clk);
    checkOutput("t4_drop_last_ready", 32'(d3_s_ready), 32'h1);
    checkOutput("t4_drop_last_o", 32'(d3_last_o), 32'h0);
    checkOutput("t4_drop_last_valid", 32'(d3_m_valid), 32'h0);
    nextCycle(); d3_s_valid = 1'b0; d3_s_last = 1'b0; @(negedge clk);
    checkOutput("t4_drop_cnt", 32'(d3_drop_cnt), 32'(EXP_DROP_CNT));
    checkOutput("t4_back_idle_ready", 32'(d3_s_ready), 32'h0);
    checkOutput("t4_request_after", 32'(d3_request), 32'h0);

    // Back-to-back single-beat packets to dest 0
    grant = 4'b0001;
    nextCycle(); applyStimulus(1'b1, 8'hE1, 1'b1, 2'd0); pushBeat(8'hE1, 1'b1);
    @(negedge clk);
    checkOutput("t5_idle_request", 32'(request), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t5_request1", 32'(request), 32'h1);
    nextCycle(); @(negedge clk);
    checkOutput("t5_last_o1", 32'(last_o), 32'h1);
    checkOutput("t5_request_held", 32'(request), 32'h1);
    nextCycle(); applyStimulus(1'b1, 8'hF1, 1'b1, 2'd0); pushBeat(8'hF1, 1'b1);
    @(negedge clk);
    checkOutput("t5_gap_request", 32'(request), 32'h0);
    checkOutput("t5_gap_last_o", 32'(last_o), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t5_request2", 32'(request), 32'h1);
    nextCycle(); @(negedge clk);
    checkOutput("t5_last_o2", 32'(last_o), 32'h1);
    nextCycle(); applyStimulus(1'b0, 8'h00, 1'b0, 2'd0); grant = 4'b0000;
    @(negedge clk);
    checkOutput("t5_request_after", 32'(request), 32'h0);

    // Reset asserted during the second beat of a 4-beat packet
    grant = 4'b0100;
    nextCycle(); applyStimulus(1'b1, 8'h61, 1'b0, 2'd2); pushBeat(8'h61, 1'b0);
    @(negedge clk);
    nextCycle(); @(negedge clk);
    checkOutput("t6_request", 32'(request), 32'h4);
    nextCycle(); @(negedge clk);
    checkOutput("t6_xfer_valid", 32'(m_valid), 32'h4);
    nextCycle(); applyStimulus(1'b1, 8'h62, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_request", 32'(request), 32'h0);
    checkOutput("t6_rst_valid", 32'(m_valid), 32'h0);
    checkOutput("t6_rst_ready", 32'(s_ready), 32'h0);
    checkOutput("t6_rst_last_o", 32'(last_o), 32'h0);
    checkOutput("t6_rst_data", 32'(m_data), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nextCycle(); applyStimulus(1'b1, 8'h71, 1'b1, 2'd2); pushBeat(8'h71, 1'b1);
    @(negedge clk);
    checkOutput("t6_post_idle_request", 32'(request), 32'h0);
    checkOutput("t6_post_idle_ready", 32'(s_ready), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("t6_post_request", 32'(request), 32'h4);
    nextCycle(); @(negedge clk);
    checkOutput("t6_post_data", 32'(m_data), 32'h71);
    checkOutput("t6_post_last_o", 32'(last_o), 32'h4);
    nextCycle(); applyStimulus(1'b0, 8'h00, 1'b0, 2'd0); grant = 4'b0000;
    @(negedge clk);
    checkOutput("t6_request_after", 32'(request), 32'h0);

    // Every queued beat must have been delivered
    checkOutput("sb_leftover_beats", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
